l2_cache_bus_queue: RTL and testbench
=====================================

Name: l2_cache_bus_queue

Overview:
Downstream of the L2 read stage's pending-miss tracker. Queues L2 misses and dirty-line writebacks, performs the system-memory write and read bursts over a 32-bit beat interface, then restarts each request into the L2 pipeline as a fill. Requests flagged duplicate by the miss tracker skip the memory read and are restarted without fill data, so a line is never loaded twice.

Parameters:
QUEUE_SIZE, 8, request FIFO depth; power of two.
ALMOST_FULL_MARGIN, 4, free slots reserved for requests already in the L2 pipeline.
REQ_INFO_WIDTH, 64, opaque request bundle carried through and returned on restart.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enq_valid  in  1  enqueue one request this cycle
enq_address  in  26  line address of the miss or restart
enq_load  in  1  line must be loaded from memory
enq_duplicate  in  1  miss already pending elsewhere; no memory read
enq_writeback  in  1  victim line is dirty; write it first
enq_wb_address  in  26  victim line address
enq_wb_data  in  512  victim line data
enq_info  in  REQ_INFO_WIDTH  opaque request bundle
queue_almost_full  out  1  stall signal to the L2 arbiter
mem_req_valid  out  1  address phase valid
mem_req_ready  in  1  address accepted
mem_req_write  out  1  1 = write burst, 0 = read burst
mem_req_addr  out  32  byte address {line,6'b0}
mem_wvalid  out  1  write beat valid
mem_wready  in  1  write beat accepted
mem_wdata  out  32  write beat
mem_rvalid  in  1  read beat valid; always accepted
mem_rdata  in  32  read beat
restart_valid  out  1  restart request to the L2 arbiter
restart_ack  in  1  arbiter accepted the restart
restart_address  out  26  line address
restart_is_fill  out  1  restart_data is valid fill data
restart_data  out  512  loaded line
restart_info  out  REQ_INFO_WIDTH  returned bundle

Behaviour:
- Reset (asynchronous): FIFO empty, state IDLE, beat counter 0. All outputs 0; queue_almost_full is 0.
- queue_almost_full = (occupancy >= QUEUE_SIZE - ALMOST_FULL_MARGIN), driven from registered occupancy.
- Enqueue while full: assertion failure; the request is dropped. Simultaneous enqueue and dequeue at full is legal, and occupancy is unchanged.
- A request with enq_valid and none of load, duplicate or writeback set is still queued and restarted (restart_is_fill=0).
- FSM operates on the FIFO head only:
  - IDLE: when the head is valid, go to WB_ADDR if writeback is set, else RD_ADDR if load is set and duplicate is clear, else RESTART.
  - WB_ADDR: mem_req_valid=1, mem_req_write=1, addr={wb_address,6'b0}. On ready, go to WB_DATA.
  - WB_DATA: 16 beats. Beat n = wb_data[32n+31:32n] (n=0 first). The counter advances on wvalid&wready. After beat 15, go to RD_ADDR if load&!duplicate, else RESTART.
  - RD_ADDR: mem_req_valid=1, write=0, addr={address,6'b0}. On ready, go to RD_DATA.
  - RD_DATA: each rvalid stores rdata into line buffer slice n, then increments n. After beat 15, go to RESTART.
  - RESTART: restart_valid=1 and outputs stable. restart_is_fill=1 only if a read was performed. On restart_ack, dequeue and go to IDLE in the same cycle, so the next head starts one cycle later.
- mem_req_valid is held until ready, and mem_wvalid is held until wready; both are AXI-style, with no retraction.
- Beat counter is 4 bits and wraps from 15 to 0 at burst end.
- rvalid outside RD_DATA: assertion failure; the beat is ignored.
- Reset mid-burst aborts the burst. The memory model is reset on the same signal.
- Ordering is strict FIFO; there is no reordering between loads and duplicates.

Decomposition:
- Package l2_cache_pkg:
  - L2_LINE_BITS=512, L2_ADDR_BITS=26, BEATS_PER_LINE=16.
  - typedef bus_queue_entry_t (address, load, duplicate, writeback, wb_address, wb_data, info).
  - enum bus_state_t {IDLE, WB_ADDR, WB_DATA, RD_ADDR, RD_DATA, RESTART}.
- Sub-module l2_request_fifo (parameterized width and depth). It provides registered count, full/empty and an almost_full threshold input.

Test Plan:
- Clean miss, address 26'h0000040: read burst at 32'h1000, beats 0..15 = k*0x11111111 -> restart_is_fill=1, restart_data slice k matches, info returned.
- Dirty miss, wb_address 26'h5, wb_data pattern, load address 26'h9: write at 32'h140 with 16 correct beats, then read at 32'h240, then restart.
- Duplicate, address 26'h9, load=1, duplicate=1: no mem_req_valid at all -> restart within 2 cycles with restart_is_fill=0.
- Backpressure: wready toggles every other cycle and restart_ack is delayed 5 cycles -> wdata is stable while stalled, and no dequeue before ack.
- Fill queue with 4 requests while the head stalls -> queue_almost_full=1 at occupancy 4. Fill to 8, then enqueue with a simultaneous ack -> occupancy stays 8 and no assertion fires.
- Assert reset at WB_DATA beat 7 -> all outputs 0 and queue empty. After release, a new request completes normally.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared types and constants for the L2 bus queue slice.
package l2_cache_pkg;

  localparam int unsigned L2_LINE_BITS      = 512;
  localparam int unsigned L2_ADDR_BITS      = 26;
  localparam int unsigned BEATS_PER_LINE    = 16;
  localparam int unsigned BEAT_BITS         = 32;
  // Widest supported request bundle; narrower bundles are zero-extended.
  localparam int unsigned L2_REQ_INFO_BITS  = 64;

  typedef struct packed {
    logic [L2_ADDR_BITS-1:0]     address;
    logic                        load;
    logic                        duplicate;
    logic                        writeback;
    logic [L2_ADDR_BITS-1:0]     wb_address;
    logic [L2_LINE_BITS-1:0]     wb_data;
    logic [L2_REQ_INFO_BITS-1:0] info;
  } bus_queue_entry_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_ADDR = 3'd1,
    WB_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESTART = 3'd5
  } bus_state_t;

endpackage

// File: rtl/l2_request_fifo.sv
// Synchronous FIFO with registered occupancy, full/empty and a programmable almost-full flag.
module l2_request_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  input  logic [$clog2(DEPTH):0]     almost_full_thresh,
  output logic                       almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign almost_full = (count_q >= almost_full_thresh);
  assign dout        = mem[rd_ptr];

  // A push at full is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push && full |-> pop);

endmodule

// File: rtl/l2_cache_bus_queue.sv
// Queues L2 misses/writebacks, runs the memory bursts and restarts each request as a fill.
module l2_cache_bus_queue
  import l2_cache_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE         = 8,
  parameter int unsigned ALMOST_FULL_MARGIN = 4,
  parameter int unsigned REQ_INFO_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  logic [25:0]               enq_address,
  input  logic                      enq_load,
  input  logic                      enq_duplicate,
  input  logic                      enq_writeback,
  input  logic [25:0]               enq_wb_address,
  input  logic [511:0]              enq_wb_data,
  input  logic [REQ_INFO_WIDTH-1:0] enq_info,
  output logic                      queue_almost_full,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [31:0]               mem_req_addr,
  output logic                      mem_wvalid,
  input  logic                      mem_wready,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic                      restart_valid,
  input  logic                      restart_ack,
  output logic [25:0]               restart_address,
  output logic                      restart_is_fill,
  output logic [511:0]              restart_data,
  output logic [REQ_INFO_WIDTH-1:0] restart_info
);

  localparam int unsigned EW = $bits(bus_queue_entry_t);
  localparam int unsigned CW = $clog2(QUEUE_SIZE) + 1;

  bus_queue_entry_t enq_entry, head;
  logic [EW-1:0]    head_bits;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty, deq;
  bus_state_t       state_q;
  logic [3:0]       beat_q;
  logic [511:0]     line_buf;
  logic             needs_read;

  always_comb begin
    enq_entry            = '0;
    enq_entry.address    = enq_address;
    enq_entry.load       = enq_load;
    enq_entry.duplicate  = enq_duplicate;
    enq_entry.writeback  = enq_writeback;
    enq_entry.wb_address = enq_wb_address;
    enq_entry.wb_data    = enq_wb_data;
    enq_entry.info       = L2_REQ_INFO_BITS'(enq_info);
  end

  l2_request_fifo #(
    .WIDTH (EW),
    .DEPTH (QUEUE_SIZE)
  ) u_fifo (
    .clk                (clk),
    .reset              (reset),
    .push               (enq_valid),
    .din                (enq_entry),
    .pop                (deq),
    .dout               (head_bits),
    .count              (fifo_count),
    .full               (fifo_full),
    .empty              (fifo_empty),
    .almost_full_thresh (CW'(QUEUE_SIZE - ALMOST_FULL_MARGIN)),
    .almost_full        (queue_almost_full)
  );

  assign head       = bus_queue_entry_t'(head_bits);
  assign needs_read = head.load && !head.duplicate;
  assign deq        = (state_q == RESTART) && restart_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      line_buf <= '0;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          if (head.writeback)  state_q <= WB_ADDR;
          else if (needs_read) state_q <= RD_ADDR;
          else                 state_q <= RESTART;
        end
        WB_ADDR: if (mem_req_ready) state_q <= WB_DATA;
        WB_DATA: if (mem_wready) begin
          beat_q <= beat_q + 4'd1;
          if (beat_q == 4'hF) state_q <= needs_read ? RD_ADDR : RESTART;
        end
        RD_ADDR: if (mem_req_ready) state_q <= RD_DATA;
        RD_DATA: if (mem_rvalid) begin
          line_buf[{beat_q, 5'b0} +: 32] <= mem_rdata;
          beat_q <= beat_q + 4'd1;
          if (beat_q == 4'hF) state_q <= RESTART;
        end
        RESTART: if (restart_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_wvalid      = 1'b0;
    mem_wdata       = '0;
    restart_valid   = 1'b0;
    restart_address = '0;
    restart_is_fill = 1'b0;
    restart_data    = '0;
    restart_info    = '0;
    case (state_q)
      WB_ADDR: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {head.wb_address, 6'b0};
      end
      WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = head.wb_data[{beat_q, 5'b0} +: 32];
      end
      RD_ADDR: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {head.address, 6'b0};
      end
      RESTART: begin
        restart_valid   = 1'b1;
        restart_address = head.address;
        restart_is_fill = needs_read;
        restart_data    = needs_read ? line_buf : '0;
        restart_info    = head.info[REQ_INFO_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  a_rvalid_in_burst: assert property (@(posedge clk) disable iff (reset)
    mem_rvalid |-> state_q == RD_DATA);
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CW'(QUEUE_SIZE));
  a_enq_full: assert property (@(posedge clk) disable iff (reset)
    enq_valid && fifo_full |-> deq);

endmodule

// File: tb/tb_l2_cache_bus_queue.sv
// Scenario bench for l2_cache_bus_queue with a line-level memory model and request queue.
module tb_l2_cache_bus_queue;
  import l2_cache_pkg::*;

  localparam int unsigned AF_LEVEL = 8 - 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enq_valid = 0, enq_load = 0, enq_duplicate = 0, enq_writeback = 0;
  logic [25:0] enq_address = '0, enq_wb_address = '0;
  logic [511:0] enq_wb_data = '0;
  logic [63:0] enq_info = '0;
  logic queue_almost_full, mem_req_valid, mem_req_write, mem_wvalid, restart_valid, restart_is_fill;
  logic mem_req_ready = 0, mem_wready = 0, mem_rvalid = 0, restart_ack = 0;
  logic [31:0] mem_req_addr, mem_wdata, mem_rdata = '0;
  logic [25:0] restart_address;
  logic [511:0] restart_data;
  logic [63:0] restart_info;
  logic [671:0] all_outs;

  assign all_outs = {mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
                     restart_valid, restart_address, restart_is_fill, restart_data,
                     restart_info, queue_almost_full};

  l2_cache_bus_queue #(.QUEUE_SIZE(8), .ALMOST_FULL_MARGIN(4), .REQ_INFO_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_address(enq_address),
    .enq_load(enq_load), .enq_duplicate(enq_duplicate), .enq_writeback(enq_writeback),
    .enq_wb_address(enq_wb_address), .enq_wb_data(enq_wb_data), .enq_info(enq_info),
    .queue_almost_full(queue_almost_full), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .restart_valid(restart_valid),
    .restart_ack(restart_ack), .restart_address(restart_address),
    .restart_is_fill(restart_is_fill), .restart_data(restart_data), .restart_info(restart_info)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0]  address;
    bit           load, dup, wb;
    logic [25:0]  wb_address;
    logic [511:0] wb_data;
    logic [63:0]  info;
  } req_t;

  int n_vec = 0;
  int n_err = 0;
  logic [511:0] mem_model [logic [25:0]];

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] mem_read(input logic [25:0] a);
    if (!mem_model.exists(a)) mem_model[a] = rand_line();
    return mem_model[a];
  endfunction

  function automatic req_t mk_req(input logic [25:0] a, input bit ld, input bit dp, input bit wb,
                                  input logic [25:0] wa);
    req_t r;
    r.address = a; r.load = ld; r.dup = dp; r.wb = wb; r.wb_address = wa;
    r.wb_data = rand_line(); r.info = {$urandom, $urandom};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_enq(input req_t r);
    enq_valid = 1; enq_address = r.address; enq_load = r.load; enq_duplicate = r.dup;
    enq_writeback = r.wb; enq_wb_address = r.wb_address; enq_wb_data = r.wb_data; enq_info = r.info;
  endtask

  task automatic enq(input req_t r);
    drive_enq(r); tick(); enq_valid = 0;
  endtask

  task automatic wait_req(input int dly, output bit wr, output logic [31:0] addr,
                          output bit to, output int dropped);
    int c = 0;
    to = 0; dropped = 0; wr = 0; addr = '0;
    while (!mem_req_valid && c < 64) begin tick(); c++; end
    if (!mem_req_valid) begin to = 1; return; end
    for (int i = 0; i < dly; i++) begin tick(); if (!mem_req_valid) dropped++; end
    wr = mem_req_write; addr = mem_req_addr;
    mem_req_ready = 1; tick(); mem_req_ready = 0;
  endtask

  // mode 0: always ready, 1: ready every other cycle, 2: random ready
  task automatic collect_write(input int mode, output logic [511:0] data, output int unstable,
                               output bit to);
    int n = 0, cyc = 0;
    bit stalled = 0, rdy;
    logic [31:0] last = '0;
    data = '0; unstable = 0;
    while (n < 16 && cyc < 200) begin
      if (mem_wvalid) begin
        if (stalled && mem_wdata !== last) unstable++;
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
        mem_wready = rdy;
        if (rdy) begin data[n*32 +: 32] = mem_wdata; n++; stalled = 0; end
        else begin stalled = 1; last = mem_wdata; end
      end else mem_wready = 0;
      tick(); cyc++;
    end
    mem_wready = 0;
    to = (n < 16);
  endtask

  task automatic supply_read(input logic [511:0] line);
    int n = 0;
    while (n < 16) begin
      if ($urandom_range(0, 3) == 0) mem_rvalid = 0;
      else begin mem_rvalid = 1; mem_rdata = line[n*32 +: 32]; n++; end
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic wait_restart(input int lim, output int cyc, output bit to, output int memreq);
    cyc = 0; memreq = 0;
    while (!restart_valid && cyc < lim) begin
      if (mem_req_valid) memreq++;
      tick(); cyc++;
    end
    to = !restart_valid;
  endtask

  task automatic ack_restart();
    restart_ack = 1; tick(); restart_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    n_vec++; if (all_outs !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", all_outs); end
    reset = 0; tick(); tick();
    n_vec++; if (all_outs !== '0) begin n_err++; $display("FAIL idle_outputs got=%h exp=0", all_outs); end
  endtask

  task automatic test_clean_miss();
    req_t r; bit wr, to; logic [31:0] a; int dr, cyc, mr; logic [511:0] pat;
    for (int k = 0; k < 16; k++) pat[k*32 +: 32] = 32'(k) * 32'h11111111;
    mem_model[26'h40] = pat;
    r = mk_req(26'h40, 1, 0, 0, '0);
    enq(r);
    wait_req($urandom_range(0, 2), wr, a, to, dr);
    n_vec++; if ({to, wr, a, dr} !== {1'b0, 1'b0, 32'h1000, 32'd0}) begin n_err++;
      $display("FAIL clean_rdreq got to=%b wr=%b addr=%h drop=%0d exp 0 0 00001000 0", to, wr, a, dr); end
    if (!to) supply_read(mem_read(r.address));
    wait_restart(20, cyc, to, mr);
    n_vec++; if ({to, restart_is_fill, restart_address} !== {1'b0, 1'b1, 26'h40}) begin n_err++;
      $display("FAIL clean_restart got to=%b fill=%b addr=%h exp 0 1 0000040", to, restart_is_fill, restart_address); end
    n_vec++; if (restart_data !== pat) begin n_err++;
      $display("FAIL clean_data got=%h exp=%h", restart_data, pat); end
    n_vec++; if (restart_info !== r.info) begin n_err++;
      $display("FAIL clean_info got=%h exp=%h", restart_info, r.info); end
    ack_restart();
    n_vec++; if (restart_valid !== 1'b0) begin n_err++; $display("FAIL clean_deq got=%b exp=0", restart_valid); end
  endtask

  task automatic test_dirty_miss();
    req_t r; bit wr, to; logic [31:0] a; int dr, cyc, mr, us; logic [511:0] d;
    r = mk_req(26'h9, 1, 0, 1, 26'h5);
    enq(r);
    wait_req(1, wr, a, to, dr);
    n_vec++; if ({to, wr, a, dr} !== {1'b0, 1'b1, 32'h140, 32'd0}) begin n_err++;
      $display("FAIL dirty_wrreq got to=%b wr=%b addr=%h drop=%0d exp 0 1 00000140 0", to, wr, a, dr); end
    collect_write(2, d, us, to);
    n_vec++; if ({to, us, d} !== {1'b0, 32'd0, r.wb_data}) begin n_err++;
      $display("FAIL dirty_wdata got to=%b unstable=%0d data=%h exp=%h", to, us, d, r.wb_data); end
    mem_model[r.wb_address] = r.wb_data;
    wait_req(0, wr, a, to, dr);
    n_vec++; if ({to, wr, a} !== {1'b0, 1'b0, 32'h240}) begin n_err++;
      $display("FAIL dirty_rdreq got to=%b wr=%b addr=%h exp 0 0 00000240", to, wr, a); end
    if (!to) supply_read(mem_read(r.address));
    wait_restart(20, cyc, to, mr);
    n_vec++; if ({to, restart_is_fill, restart_data, restart_info} !== {1'b0, 1'b1, mem_read(r.address), r.info}) begin
      n_err++; $display("FAIL dirty_restart got to=%b fill=%b data=%h info=%h exp fill=1 data=%h info=%h",
        to, restart_is_fill, restart_data, restart_info, mem_read(r.address), r.info); end
    ack_restart();
  endtask

  task automatic test_duplicate();
    req_t r; bit to; int cyc, mr;
    r = mk_req(26'h9, 1, 1, 0, '0);
    enq(r);
    wait_restart(2, cyc, to, mr);
    n_vec++; if ({to, mr} !== {1'b0, 32'd0}) begin n_err++;
      $display("FAIL dup_latency got timeout=%b memreq=%0d exp 0 0", to, mr); end
    n_vec++; if ({restart_is_fill, restart_address, restart_info} !== {1'b0, 26'h9, r.info}) begin n_err++;
      $display("FAIL dup_restart got fill=%b addr=%h info=%h exp 0 0000009 %h",
        restart_is_fill, restart_address, restart_info, r.info); end
    ack_restart();
  endtask

  task automatic test_backpressure();
    req_t r, r2; bit wr, to; logic [31:0] a; int dr, cyc, mr, us, bad = 0; logic [511:0] d;
    r  = mk_req(26'h33, 0, 0, 1, 26'h77);
    r2 = mk_req(26'h21, 0, 0, 0, '0);
    enq(r);
    wait_req(3, wr, a, to, dr);
    n_vec++; if ({to, wr, a, dr} !== {1'b0, 1'b1, {26'h77, 6'b0}, 32'd0}) begin n_err++;
      $display("FAIL bp_wrreq got to=%b wr=%b addr=%h drop=%0d exp 0 1 %h 0", to, wr, a, dr, {26'h77, 6'b0}); end
    collect_write(1, d, us, to);
    n_vec++; if ({to, us, d} !== {1'b0, 32'd0, r.wb_data}) begin n_err++;
      $display("FAIL bp_wdata got to=%b unstable=%0d data=%h exp=%h", to, us, d, r.wb_data); end
    wait_restart(20, cyc, to, mr);
    enq(r2);
    for (int i = 0; i < 5; i++) begin
      if ({restart_valid, restart_is_fill, restart_address, restart_info} !== {1'b1, 1'b0, r.address, r.info}) bad++;
      tick();
    end
    n_vec++; if ({to, bad} !== {1'b0, 32'd0}) begin n_err++;
      $display("FAIL bp_hold got timeout=%b unstable_cycles=%0d exp 0 0", to, bad); end
    ack_restart();
    wait_restart(4, cyc, to, mr);
    n_vec++; if ({to, restart_info} !== {1'b0, r2.info}) begin n_err++;
      $display("FAIL bp_next got to=%b info=%h exp 0 %h", to, restart_info, r2.info); end
    ack_restart();
  endtask

  task automatic test_fill();
    req_t q[$]; req_t r, nr; bit to; int cyc, mr, occ = 0;
    for (int k = 0; k < 8; k++) begin
      r = mk_req(26'($urandom_range(0, 255)), k == 0 || bit'($urandom_range(0, 1)), 1'b1, 0, '0);
      if (k > 0 && $urandom_range(0, 1) == 1) r.dup = 0;
      if (!r.dup) r.load = 0;
      enq(r); q.push_back(r); occ++;
      n_vec++; if (queue_almost_full !== (occ >= AF_LEVEL)) begin n_err++;
        $display("FAIL fill_af occ=%0d got=%b exp=%b", occ, queue_almost_full, occ >= AF_LEVEL); end
    end
    wait_restart(4, cyc, to, mr);
    nr = mk_req(26'h123, 0, 0, 0, '0);
    drive_enq(nr); restart_ack = 1; tick(); enq_valid = 0; restart_ack = 0;
    void'(q.pop_front()); q.push_back(nr);
    n_vec++; if ({to, queue_almost_full} !== {1'b0, 1'b1}) begin n_err++;
      $display("FAIL full_swap got to=%b af=%b exp 0 1", to, queue_almost_full); end
    while (q.size() > 0) begin
      r = q.pop_front();
      wait_restart(4, cyc, to, mr);
      n_vec++; if ({to, mr, restart_address, restart_info, restart_is_fill} !== {1'b0, 32'd0, r.address, r.info, 1'b0}) begin
        n_err++; $display("FAIL drain got to=%b memreq=%0d addr=%h info=%h fill=%b exp addr=%h info=%h fill=0",
          to, mr, restart_address, restart_info, restart_is_fill, r.address, r.info); end
      ack_restart();
      n_vec++; if (queue_almost_full !== (q.size() >= AF_LEVEL)) begin n_err++;
        $display("FAIL drain_af occ=%0d got=%b exp=%b", q.size(), queue_almost_full, q.size() >= AF_LEVEL); end
    end
  endtask

  task automatic test_reset_mid_burst();
    req_t r; bit wr, to; logic [31:0] a; int dr, cyc, mr, bad = 0, busy = 0;
    r = mk_req(26'h2A, 1, 0, 1, 26'h15);
    enq(r); enq(mk_req(26'h3, 0, 0, 0, '0)); enq(mk_req(26'h4, 1, 1, 0, '0));
    wait_req(0, wr, a, to, dr);
    for (int i = 0; i < 7; i++) begin
      mem_wready = 1;
      if ({mem_wvalid, mem_wdata} !== {1'b1, r.wb_data[i*32 +: 32]}) bad++;
      tick();
    end
    mem_wready = 0;
    n_vec++; if ({to, bad} !== {1'b0, 32'd0}) begin n_err++;
      $display("FAIL rst_prebeats got to=%b bad_beats=%0d exp 0 0", to, bad); end
    #2 reset = 1;
    #1;
    n_vec++; if (all_outs !== '0) begin n_err++; $display("FAIL async_reset got=%h exp=0", all_outs); end
    tick(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_valid || restart_valid || mem_wvalid || queue_almost_full) busy++;
      tick();
    end
    n_vec++; if (busy !== 0) begin n_err++; $display("FAIL rst_queue_empty got busy=%0d exp=0", busy); end
    r = mk_req(26'h1F0, 1, 0, 0, '0);
    enq(r);
    wait_req(0, wr, a, to, dr);
    n_vec++; if ({to, wr, a} !== {1'b0, 1'b0, {26'h1F0, 6'b0}}) begin n_err++;
      $display("FAIL post_rst_req got to=%b wr=%b addr=%h exp 0 0 %h", to, wr, a, {26'h1F0, 6'b0}); end
    if (!to) supply_read(mem_read(r.address));
    wait_restart(20, cyc, to, mr);
    n_vec++; if ({to, restart_is_fill, restart_data, restart_info} !== {1'b0, 1'b1, mem_read(r.address), r.info}) begin
      n_err++; $display("FAIL post_rst_restart got to=%b fill=%b data=%h info=%h", to, restart_is_fill, restart_data, restart_info); end
    ack_restart();
  endtask

  task automatic test_random();
    req_t q[$]; req_t r; bit wr, to, fill; logic [31:0] a; int dr, cyc, mr, us; logic [511:0] d, exp_line;
    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        r = mk_req(26'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   bit'($urandom_range(0, 1)), 26'($urandom_range(0, 15)));
        enq(r); q.push_back(r);
      end
      while (q.size() > 0) begin
        r = q.pop_front();
        fill = r.load && !r.dup;
        if (r.wb) begin
          wait_req($urandom_range(0, 2), wr, a, to, dr);
          n_vec++; if ({to, wr, a, dr} !== {1'b0, 1'b1, {r.wb_address, 6'b0}, 32'd0}) begin n_err++;
            $display("FAIL rnd_wrreq got to=%b wr=%b addr=%h exp addr=%h", to, wr, a, {r.wb_address, 6'b0}); end
          collect_write(2, d, us, to);
          n_vec++; if ({to, us, d} !== {1'b0, 32'd0, r.wb_data}) begin n_err++;
            $display("FAIL rnd_wdata got to=%b unstable=%0d data=%h exp=%h", to, us, d, r.wb_data); end
          mem_model[r.wb_address] = r.wb_data;
        end
        exp_line = mem_read(r.address);
        if (fill) begin
          wait_req($urandom_range(0, 2), wr, a, to, dr);
          n_vec++; if ({to, wr, a} !== {1'b0, 1'b0, {r.address, 6'b0}}) begin n_err++;
            $display("FAIL rnd_rdreq got to=%b wr=%b addr=%h exp addr=%h", to, wr, a, {r.address, 6'b0}); end
          if (!to) supply_read(exp_line);
        end
        wait_restart(20, cyc, to, mr);
        n_vec++; if ({to, mr, restart_address, restart_is_fill, restart_info} !== {1'b0, 32'd0, r.address, fill, r.info}) begin
          n_err++; $display("FAIL rnd_restart got to=%b memreq=%0d addr=%h fill=%b info=%h exp addr=%h fill=%b info=%h",
            to, mr, restart_address, restart_is_fill, restart_info, r.address, fill, r.info); end
        if (fill) begin
          n_vec++; if (restart_data !== exp_line) begin n_err++;
            $display("FAIL rnd_data got=%h exp=%h", restart_data, exp_line); end
        end
        for (int i = $urandom_range(0, 2); i > 0; i--) tick();
        ack_restart();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_duplicate();
    test_backpressure();
    test_fill();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
